// File: rtl/datapath_unit_pkg.sv
// Shared definitions for the multiply-by-constant datapath.
// Condition word encoding and enable priority select.
package datapath_unit_pkg;

    // Width of the condition words returned to the controller
    localparam int COND_W = 32;
    // Width of the iteration counter
    localparam int CNT_W = 32;

    localparam logic [COND_W-1:0] COND_TRUE  = 32'd1;
    localparam logic [COND_W-1:0] COND_FALSE = 32'd0;

    // Bit positions of the one-hot enable select, highest priority first
    localparam int SEL_BIT_E3  = 0;
    localparam int SEL_BIT_E7  = 1;
    localparam int SEL_BIT_E9  = 2;
    localparam int SEL_BIT_E10 = 3;

    typedef enum logic [3:0] {
        SEL_NONE = 4'b0000,
        SEL_E3   = 4'b0001,
        SEL_E7   = 4'b0010,
        SEL_E9   = 4'b0100,
        SEL_E10  = 4'b1000
    } en_sel_e;

    // Resolve simultaneous strobes to the single winning enable
    function automatic en_sel_e enable_select(
        input logic e3,
        input logic e7,
        input logic e9,
        input logic e10
    );
        en_sel_e sel;
        sel = SEL_NONE;
        priority case (1'b1)
            e3:      sel = SEL_E3;
            e7:      sel = SEL_E7;
            e9:      sel = SEL_E9;
            e10:     sel = SEL_E10;
            default: sel = SEL_NONE;
        endcase
        return sel;
    endfunction

    // True when more than one strobe is high at once
    function automatic logic multi_enable(
        input logic e3,
        input logic e7,
        input logic e9,
        input logic e10
    );
        logic [2:0] n;
        n = 3'(e3) + 3'(e7) + 3'(e9) + 3'(e10);
        return n > 3'd1;
    endfunction

    // Map a boolean onto a zero-extended condition word
    function automatic logic [COND_W-1:0] cond_word(input logic b);
        return b ? COND_TRUE : COND_FALSE;
    endfunction

endpackage

// File: rtl/datapath_unit_acc_counter.sv
// Accumulator and iteration counter for repeated addition.
// Counter saturates; done compares against the iteration target.
module acc_counter
    import datapath_unit_pkg::*;
#(
    parameter int          WIDTH = 32,
    parameter int unsigned COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             step,
    input  logic [WIDTH-1:0] addend,
    output logic [WIDTH-1:0] acc,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    localparam logic [CNT_W-1:0] TARGET = CNT_W'(COUNT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Clear on load, otherwise add one operand per step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (clr) begin
            acc <= '0;
            cnt <= '0;
        end else if (step) begin
            acc <= acc + addend;
            if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Iteration target reached
    always_comb begin
        done = (cnt == TARGET);
    end

endmodule

// File: rtl/datapath_unit.sv
// Datapath side of the controller/datapath pair.
// Signed multiply by COUNT via sign-fix and repeated addition.
module datapath_unit
    import datapath_unit_pkg::*;
#(
    parameter int          WIDTH = 32,
    parameter int unsigned COUNT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              Enable3,
    input  logic              Enable7,
    input  logic              Enable9,
    input  logic              Enable10,
    output logic [COND_W-1:0] output2,
    output logic [COND_W-1:0] output5,
    output logic [COND_W-1:0] output8,
    output logic [WIDTH-1:0]  result,
    output logic              result_valid,
    output logic              enable_err
);

    en_sel_e          sel;
    logic             multi;
    logic             start_q;
    logic [WIDTH-1:0] reg_a;
    logic             neg_q;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             done;
    logic             do_load;
    logic             do_neg;
    logic             do_commit;
    logic             do_step;

    // Pick the single acting enable and flag protocol violations
    always_comb begin
        sel       = enable_select(Enable3, Enable7, Enable9, Enable10);
        multi     = multi_enable(Enable3, Enable7, Enable9, Enable10);
        do_load   = sel[SEL_BIT_E3];
        do_neg    = sel[SEL_BIT_E7];
        do_commit = sel[SEL_BIT_E9];
        do_step   = sel[SEL_BIT_E10];
    end

    // Sticky request; a new request beats a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q <= 1'b0;
        end else if (start) begin
            start_q <= 1'b1;
        end else if (do_load) begin
            start_q <= 1'b0;
        end
    end

    // Operand load and sign fix; negating the minimum wraps to itself
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_a <= '0;
            neg_q <= 1'b0;
        end else if (do_load) begin
            reg_a <= data_in;
            neg_q <= 1'b0;
        end else if (do_neg) begin
            reg_a <= -reg_a;
            neg_q <= 1'b1;
        end
    end

    acc_counter #(
        .WIDTH (WIDTH),
        .COUNT (COUNT)
    ) u_acc (
        .clk    (clk),
        .rst    (rst),
        .clr    (do_load),
        .step   (do_step),
        .addend (reg_a),
        .acc    (acc),
        .cnt    (cnt),
        .done   (done)
    );

    // Commit the sign-corrected product and pulse valid once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= do_commit;
            if (do_commit) begin
                result <= neg_q ? -acc : acc;
            end
        end
    end

    // Sticky record of overlapping enables
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_err <= 1'b0;
        end else if (multi) begin
            enable_err <= 1'b1;
        end
    end

    // Branch conditions come only from registered state
    always_comb begin
        output2 = cond_word(start_q);
        output5 = cond_word(~reg_a[WIDTH-1]);
        output8 = cond_word(done);
    end

endmodule

// File: tb/tb_datapath_unit.sv
// Directed bench for datapath_unit with a result scoreboard.
// Checks COUNT=4 and COUNT=0 builds.
module tb_datapath_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] data_in = '0;
    logic        e3 = 1'b0;
    logic        e7 = 1'b0;
    logic        e9 = 1'b0;
    logic        e10 = 1'b0;

    logic [31:0] o2, o5, o8, res;
    logic        vld, err;
    logic [31:0] z_o2, z_o5, z_o8, z_res;
    logic        z_vld, z_err;

    int n_assert = 0;
    int n_fail = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    datapath_unit #(.WIDTH(32), .COUNT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .Enable3(e3), .Enable7(e7), .Enable9(e9), .Enable10(e10),
        .output2(o2), .output5(o5), .output8(o8),
        .result(res), .result_valid(vld), .enable_err(err)
    );

    datapath_unit #(.WIDTH(32), .COUNT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .Enable3(e3), .Enable7(e7), .Enable9(e9), .Enable10(e10),
        .output2(z_o2), .output5(z_o5), .output8(z_o8),
        .result(z_res), .result_valid(z_vld), .enable_err(z_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock with the given strobes; commits push their expected value
    task automatic cyc(input logic a3, input logic a7, input logic a9,
                       input logic a10, input logic st,
                       input logic [31:0] d, input logic [31:0] exp);
        e3 = a3; e7 = a7; e9 = a9; e10 = a10; start = st; data_in = d;
        if (a9) sb.push_back(exp);
        @(posedge clk);
        #1;
        e3 = 0; e7 = 0; e9 = 0; e10 = 0; start = 0;
    endtask

    task automatic step10(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 0, 0, 0);
    endtask

    // Scoreboard: every valid pulse must match a queued commit
    always @(negedge clk) begin
        if (!rst && vld) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", {31'd0, vld}, 32'd0);
            end else begin
                chk("result", res, sb.pop_front());
            end
        end
    end

    initial begin
        #12;
        chk("rst_o2", o2, 32'd0);
        chk("rst_o5", o5, 32'd1);
        chk("rst_o8", o8, 32'd0);
        chk("rst_res", res, 32'd0);
        chk("rst_vld", {31'd0, vld}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_o8_count0", z_o8, 32'd1);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;

        // 5 * 4
        cyc(0, 0, 0, 0, 1, 0, 0);
        chk("req_o2", o2, 32'd1);
        cyc(1, 0, 0, 0, 0, 32'd5, 0);
        chk("load_o2", o2, 32'd0);
        chk("load5_o5", o5, 32'd1);
        chk("load_o8", o8, 32'd0);
        step10(3);
        chk("three_o8", o8, 32'd0);
        step10(1);
        chk("four_o8", o8, 32'd1);
        cyc(0, 0, 1, 0, 0, 0, 32'd20);
        chk("commit_vld", {31'd0, vld}, 32'd1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("pulse_one_cycle", {31'd0, vld}, 32'd0);
        chk("hold_res", res, 32'd20);

        // -3 * 4 with start colliding with load
        cyc(1, 0, 0, 0, 1, 32'hFFFF_FFFD, 0);
        chk("start_wins_o2", o2, 32'd1);
        chk("neg_o5", o5, 32'd0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("negated_o5", o5, 32'd1);
        step10(2);
        cyc(0, 0, 0, 0, 1, 0, 0);
        chk("mid_start_o2", o2, 32'd1);
        step10(2);
        chk("neg_o8", o8, 32'd1);
        cyc(0, 0, 1, 0, 0, 0, 32'hFFFF_FFF4);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("neg_hold", res, 32'hFFFF_FFF4);

        // 0 * 4
        cyc(1, 0, 0, 0, 0, 32'd0, 0);
        chk("zero_o5", o5, 32'd1);
        step10(4);
        cyc(0, 0, 1, 0, 0, 0, 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Async reset mid-accumulation
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 32'd9, 0);
        step10(2);
        #2;
        rst = 1;
        #1;
        chk("arst_res", res, 32'd0);
        chk("arst_o2", o2, 32'd0);
        chk("arst_o5", o5, 32'd1);
        chk("arst_o8", o8, 32'd0);
        chk("arst_vld", {31'd0, vld}, 32'd0);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        cyc(1, 0, 0, 0, 0, 32'd7, 0);
        step10(4);
        cyc(0, 0, 1, 0, 0, 0, 32'd28);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // COUNT=0 build: load then commit directly
        cyc(1, 0, 0, 0, 0, 32'd11, 0);
        chk("count0_o8", z_o8, 32'd1);
        chk("count4_o8_load", o8, 32'd0);
        cyc(0, 0, 1, 0, 0, 0, 32'd0);
        chk("count0_res", z_res, 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Overlapping enables: only the negation acts
        chk("pre_err", {31'd0, err}, 32'd0);
        cyc(1, 0, 0, 0, 0, 32'd2, 0);
        step10(1);
        cyc(0, 1, 0, 1, 0, 0, 0);
        chk("viol_err", {31'd0, err}, 32'd1);
        chk("viol_o5", o5, 32'd0);
        step10(2);
        chk("viol_cnt_held", o8, 32'd0);
        step10(1);
        chk("viol_cnt_four", o8, 32'd1);
        cyc(0, 0, 1, 0, 0, 0, 32'd4);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("err_sticky", {31'd0, err}, 32'd1);
        chk("sb_drained", sb.size(), 32'd0);
        rst = 1;
        #1;
        chk("err_cleared", {31'd0, err}, 32'd0);
        #20;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
